// File: rtl/axi_arbiter_2m1s.sv
// -----------------------------------------------------------------------------
// axi_arbiter_2m1s
//
// Shares one upstream AXI4 port between two requesters:
//   m0 : instruction fetch (read only: AR, R)
//   m1 : load/store unit   (read and write: AR, R, AW, W, B)
//   s  : single downstream port toward the crossbar
//
// Only one transaction is in flight at a time. Once granted, the owner keeps
// the port from its address handshake through its final response (last R
// beat, or the B response). Writes take priority over reads. Between the two
// readers a round-robin pointer (last) picks whoever was not served last.
//
// Ports:
//   clk_i, rst_n_i               clock, asynchronous active-low reset
//   m0_ar*_i / m0_arready_o      m0 read address channel
//   m0_r*_o  / m0_rready_i       m0 read data channel
//   m1_ar*, m1_r*                m1 read channels (same shapes as m0)
//   m1_aw*, m1_w*, m1_b*         m1 write channels
//   s_ar*, s_r*, s_aw*, s_w*, s_b*  downstream channels
// -----------------------------------------------------------------------------
module axi_arbiter_2m1s #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,

  // m0 read address / data
  input  logic [ID_W-1:0]     m0_arid_i,
  input  logic [ADDR_W-1:0]   m0_araddr_i,
  input  logic [7:0]          m0_arlen_i,
  input  logic [2:0]          m0_arsize_i,
  input  logic [1:0]          m0_arburst_i,
  input  logic                m0_arvalid_i,
  output logic                m0_arready_o,
  output logic [ID_W-1:0]     m0_rid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic [1:0]          m0_rresp_o,
  output logic                m0_rlast_o,
  output logic                m0_rvalid_o,
  input  logic                m0_rready_i,

  // m1 read address / data
  input  logic [ID_W-1:0]     m1_arid_i,
  input  logic [ADDR_W-1:0]   m1_araddr_i,
  input  logic [7:0]          m1_arlen_i,
  input  logic [2:0]          m1_arsize_i,
  input  logic [1:0]          m1_arburst_i,
  input  logic                m1_arvalid_i,
  output logic                m1_arready_o,
  output logic [ID_W-1:0]     m1_rid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic [1:0]          m1_rresp_o,
  output logic                m1_rlast_o,
  output logic                m1_rvalid_o,
  input  logic                m1_rready_i,

  // m1 write address / data / response
  input  logic [ID_W-1:0]     m1_awid_i,
  input  logic [ADDR_W-1:0]   m1_awaddr_i,
  input  logic [7:0]          m1_awlen_i,
  input  logic [2:0]          m1_awsize_i,
  input  logic [1:0]          m1_awburst_i,
  input  logic                m1_awvalid_i,
  output logic                m1_awready_o,
  input  logic [ID_W-1:0]     m1_wid_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  input  logic                m1_wlast_i,
  input  logic                m1_wvalid_i,
  output logic                m1_wready_o,
  output logic [ID_W-1:0]     m1_bid_o,
  output logic [1:0]          m1_bresp_o,
  output logic                m1_bvalid_o,
  input  logic                m1_bready_i,

  // downstream read channels
  output logic [ID_W-1:0]     s_arid_o,
  output logic [ADDR_W-1:0]   s_araddr_o,
  output logic [7:0]          s_arlen_o,
  output logic [2:0]          s_arsize_o,
  output logic [1:0]          s_arburst_o,
  output logic                s_arvalid_o,
  input  logic                s_arready_i,
  input  logic [ID_W-1:0]     s_rid_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic [1:0]          s_rresp_i,
  input  logic                s_rlast_i,
  input  logic                s_rvalid_i,
  output logic                s_rready_o,

  // downstream write channels
  output logic [ID_W-1:0]     s_awid_o,
  output logic [ADDR_W-1:0]   s_awaddr_o,
  output logic [7:0]          s_awlen_o,
  output logic [2:0]          s_awsize_o,
  output logic [1:0]          s_awburst_o,
  output logic                s_awvalid_o,
  input  logic                s_awready_i,
  output logic [ID_W-1:0]     s_wid_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  output logic                s_wlast_o,
  output logic                s_wvalid_o,
  input  logic                s_wready_i,
  input  logic [ID_W-1:0]     s_bid_i,
  input  logic [1:0]          s_bresp_i,
  input  logic                s_bvalid_i,
  output logic                s_bready_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    WR1  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;       // 0: m0 served last, 1: m1 served last
  logic   a_done_q, a_done_d;   // address handshake of current grant done

  // Handshake events on the downstream side
  logic ar_hs, aw_hs, r_done, b_done;

  // Read-owner selection; only meaningful in RD0/RD1
  logic rd_sel_m1;

  assign rd_sel_m1 = (state_q == RD1);
  assign ar_hs     = s_arvalid_o & s_arready_i;
  assign aw_hs     = s_awvalid_o & s_awready_i;
  assign r_done    = s_rvalid_i & s_rready_o & s_rlast_i;
  assign b_done    = s_bvalid_i & s_bready_o;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;   // m0 wins the first read tie after reset
      a_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      a_done_q <= a_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: arbitration in IDLE, completion tracking in grant states
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    a_done_d = a_done_q;
    case (state_q)
      IDLE: begin
        if (m1_awvalid_i) begin
          state_d  = WR1;
          last_d   = 1'b1;
          a_done_d = 1'b0;
        end else if (m0_arvalid_i && m1_arvalid_i) begin
          // Tie between readers: serve whoever was not served last
          if (last_q) begin
            state_d = RD0;
            last_d  = 1'b0;
          end else begin
            state_d = RD1;
            last_d  = 1'b1;
          end
          a_done_d = 1'b0;
        end else if (m0_arvalid_i) begin
          state_d  = RD0;
          last_d   = 1'b0;
          a_done_d = 1'b0;
        end else if (m1_arvalid_i) begin
          state_d  = RD1;
          last_d   = 1'b1;
          a_done_d = 1'b0;
        end
      end
      RD0, RD1: begin
        if (ar_hs) begin
          a_done_d = 1'b1;
        end
        if (r_done) begin
          state_d = IDLE;
        end
      end
      WR1: begin
        if (aw_hs) begin
          a_done_d = 1'b1;
        end
        if (b_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Channel steering. Everything defaults to zero so that the non-owner and
  // the idle port see no valids, no readies and a quiet payload.
  // ---------------------------------------------------------------------------
  always_comb begin
    m0_arready_o = 1'b0;
    m0_rid_o     = '0;
    m0_rdata_o   = '0;
    m0_rresp_o   = '0;
    m0_rlast_o   = 1'b0;
    m0_rvalid_o  = 1'b0;
    m1_arready_o = 1'b0;
    m1_rid_o     = '0;
    m1_rdata_o   = '0;
    m1_rresp_o   = '0;
    m1_rlast_o   = 1'b0;
    m1_rvalid_o  = 1'b0;
    m1_awready_o = 1'b0;
    m1_wready_o  = 1'b0;
    m1_bid_o     = '0;
    m1_bresp_o   = '0;
    m1_bvalid_o  = 1'b0;
    s_arid_o     = '0;
    s_araddr_o   = '0;
    s_arlen_o    = '0;
    s_arsize_o   = '0;
    s_arburst_o  = '0;
    s_arvalid_o  = 1'b0;
    s_rready_o   = 1'b0;
    s_awid_o     = '0;
    s_awaddr_o   = '0;
    s_awlen_o    = '0;
    s_awsize_o   = '0;
    s_awburst_o  = '0;
    s_awvalid_o  = 1'b0;
    s_wid_o      = '0;
    s_wdata_o    = '0;
    s_wstrb_o    = '0;
    s_wlast_o    = 1'b0;
    s_wvalid_o   = 1'b0;
    s_bready_o   = 1'b0;

    case (state_q)
      RD0, RD1: begin
        // AR is only forwarded until its handshake; afterwards the owner
        // sees arready=0 so a second request cannot slip through the lock.
        if (!a_done_q) begin
          if (rd_sel_m1) begin
            s_arid_o     = m1_arid_i;
            s_araddr_o   = m1_araddr_i;
            s_arlen_o    = m1_arlen_i;
            s_arsize_o   = m1_arsize_i;
            s_arburst_o  = m1_arburst_i;
            s_arvalid_o  = m1_arvalid_i;
            m1_arready_o = s_arready_i;
          end else begin
            s_arid_o     = m0_arid_i;
            s_araddr_o   = m0_araddr_i;
            s_arlen_o    = m0_arlen_i;
            s_arsize_o   = m0_arsize_i;
            s_arburst_o  = m0_arburst_i;
            s_arvalid_o  = m0_arvalid_i;
            m0_arready_o = s_arready_i;
          end
        end
        // R is forwarded for the whole grant, including any response that
        // shows up ahead of the AR handshake.
        if (rd_sel_m1) begin
          m1_rid_o    = s_rid_i;
          m1_rdata_o  = s_rdata_i;
          m1_rresp_o  = s_rresp_i;
          m1_rlast_o  = s_rlast_i;
          m1_rvalid_o = s_rvalid_i;
          s_rready_o  = m1_rready_i;
        end else begin
          m0_rid_o    = s_rid_i;
          m0_rdata_o  = s_rdata_i;
          m0_rresp_o  = s_rresp_i;
          m0_rlast_o  = s_rlast_i;
          m0_rvalid_o = s_rvalid_i;
          s_rready_o  = m0_rready_i;
        end
      end
      WR1: begin
        if (!a_done_q) begin
          s_awid_o     = m1_awid_i;
          s_awaddr_o   = m1_awaddr_i;
          s_awlen_o    = m1_awlen_i;
          s_awsize_o   = m1_awsize_i;
          s_awburst_o  = m1_awburst_i;
          s_awvalid_o  = m1_awvalid_i;
          m1_awready_o = s_awready_i;
        end
        // W is independent of AW ordering, so it is open for the whole grant
        s_wid_o     = m1_wid_i;
        s_wdata_o   = m1_wdata_i;
        s_wstrb_o   = m1_wstrb_i;
        s_wlast_o   = m1_wlast_i;
        s_wvalid_o  = m1_wvalid_i;
        m1_wready_o = s_wready_i;
        m1_bid_o    = s_bid_i;
        m1_bresp_o  = s_bresp_i;
        m1_bvalid_o = s_bvalid_i;
        s_bready_o  = m1_bready_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_arbiter_2m1s.sv
module tb_axi_arbiter_2m1s;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [ID_W-1:0] m0_arid_i, m1_arid_i, m1_awid_i, m1_wid_i, s_rid_i, s_bid_i;
  logic [ADDR_W-1:0] m0_araddr_i, m1_araddr_i, m1_awaddr_i;
  logic [7:0] m0_arlen_i, m1_arlen_i, m1_awlen_i;
  logic [2:0] m0_arsize_i, m1_arsize_i, m1_awsize_i;
  logic [1:0] m0_arburst_i, m1_arburst_i, m1_awburst_i, s_rresp_i, s_bresp_i;
  logic m0_arvalid_i, m1_arvalid_i, m1_awvalid_i, m1_wvalid_i, m1_wlast_i;
  logic m0_rready_i, m1_rready_i, m1_bready_i;
  logic [DATA_W-1:0] m1_wdata_i, s_rdata_i;
  logic [3:0] m1_wstrb_i;
  logic s_arready_i, s_rlast_i, s_rvalid_i, s_awready_i, s_wready_i, s_bvalid_i;

  logic m0_arready_o, m1_arready_o, m0_rlast_o, m1_rlast_o, m0_rvalid_o, m1_rvalid_o;
  logic [ID_W-1:0] m0_rid_o, m1_rid_o, m1_bid_o, s_arid_o, s_awid_o, s_wid_o;
  logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o, s_wdata_o;
  logic [1:0] m0_rresp_o, m1_rresp_o, m1_bresp_o, s_arburst_o, s_awburst_o;
  logic m1_awready_o, m1_wready_o, m1_bvalid_o;
  logic [ADDR_W-1:0] s_araddr_o, s_awaddr_o;
  logic [7:0] s_arlen_o, s_awlen_o;
  logic [2:0] s_arsize_o, s_awsize_o;
  logic s_arvalid_o, s_rready_o, s_awvalid_o, s_wlast_o, s_wvalid_o, s_bready_o;
  logic [3:0] s_wstrb_o;

  axi_arbiter_2m1s #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_arid_i(m0_arid_i), .m0_araddr_i(m0_araddr_i), .m0_arlen_i(m0_arlen_i),
    .m0_arsize_i(m0_arsize_i), .m0_arburst_i(m0_arburst_i), .m0_arvalid_i(m0_arvalid_i),
    .m0_arready_o(m0_arready_o), .m0_rid_o(m0_rid_o), .m0_rdata_o(m0_rdata_o),
    .m0_rresp_o(m0_rresp_o), .m0_rlast_o(m0_rlast_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_rready_i(m0_rready_i),
    .m1_arid_i(m1_arid_i), .m1_araddr_i(m1_araddr_i), .m1_arlen_i(m1_arlen_i),
    .m1_arsize_i(m1_arsize_i), .m1_arburst_i(m1_arburst_i), .m1_arvalid_i(m1_arvalid_i),
    .m1_arready_o(m1_arready_o), .m1_rid_o(m1_rid_o), .m1_rdata_o(m1_rdata_o),
    .m1_rresp_o(m1_rresp_o), .m1_rlast_o(m1_rlast_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rready_i(m1_rready_i),
    .m1_awid_i(m1_awid_i), .m1_awaddr_i(m1_awaddr_i), .m1_awlen_i(m1_awlen_i),
    .m1_awsize_i(m1_awsize_i), .m1_awburst_i(m1_awburst_i), .m1_awvalid_i(m1_awvalid_i),
    .m1_awready_o(m1_awready_o), .m1_wid_i(m1_wid_i), .m1_wdata_i(m1_wdata_i),
    .m1_wstrb_i(m1_wstrb_i), .m1_wlast_i(m1_wlast_i), .m1_wvalid_i(m1_wvalid_i),
    .m1_wready_o(m1_wready_o), .m1_bid_o(m1_bid_o), .m1_bresp_o(m1_bresp_o),
    .m1_bvalid_o(m1_bvalid_o), .m1_bready_i(m1_bready_i),
    .s_arid_o(s_arid_o), .s_araddr_o(s_araddr_o), .s_arlen_o(s_arlen_o),
    .s_arsize_o(s_arsize_o), .s_arburst_o(s_arburst_o), .s_arvalid_o(s_arvalid_o),
    .s_arready_i(s_arready_i), .s_rid_i(s_rid_i), .s_rdata_i(s_rdata_i),
    .s_rresp_i(s_rresp_i), .s_rlast_i(s_rlast_i), .s_rvalid_i(s_rvalid_i),
    .s_rready_o(s_rready_o),
    .s_awid_o(s_awid_o), .s_awaddr_o(s_awaddr_o), .s_awlen_o(s_awlen_o),
    .s_awsize_o(s_awsize_o), .s_awburst_o(s_awburst_o), .s_awvalid_o(s_awvalid_o),
    .s_awready_i(s_awready_i), .s_wid_o(s_wid_o), .s_wdata_o(s_wdata_o),
    .s_wstrb_o(s_wstrb_o), .s_wlast_o(s_wlast_o), .s_wvalid_o(s_wvalid_o),
    .s_wready_i(s_wready_i), .s_bid_i(s_bid_i), .s_bresp_i(s_bresp_i),
    .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o)
  );

  // Packed views of each payload bundle
  logic [48:0] m0_ar_pl, m1_ar_pl, m1_aw_pl, s_ar_pl, s_aw_pl;
  logic [40:0] m1_w_pl, s_w_pl;
  logic [38:0] s_r_pl, m0_r_pl, m1_r_pl;
  logic [5:0]  s_b_pl, m1_b_pl;
  assign m0_ar_pl = {m0_arid_i, m0_araddr_i, m0_arlen_i, m0_arsize_i, m0_arburst_i};
  assign m1_ar_pl = {m1_arid_i, m1_araddr_i, m1_arlen_i, m1_arsize_i, m1_arburst_i};
  assign m1_aw_pl = {m1_awid_i, m1_awaddr_i, m1_awlen_i, m1_awsize_i, m1_awburst_i};
  assign s_ar_pl  = {s_arid_o, s_araddr_o, s_arlen_o, s_arsize_o, s_arburst_o};
  assign s_aw_pl  = {s_awid_o, s_awaddr_o, s_awlen_o, s_awsize_o, s_awburst_o};
  assign m1_w_pl  = {m1_wid_i, m1_wdata_i, m1_wstrb_i, m1_wlast_i};
  assign s_w_pl   = {s_wid_o, s_wdata_o, s_wstrb_o, s_wlast_o};
  assign s_r_pl   = {s_rid_i, s_rdata_i, s_rresp_i, s_rlast_i};
  assign m0_r_pl  = {m0_rid_o, m0_rdata_o, m0_rresp_o, m0_rlast_o};
  assign m1_r_pl  = {m1_rid_o, m1_rdata_o, m1_rresp_o, m1_rlast_o};
  assign s_b_pl   = {s_bid_i, s_bresp_i};
  assign m1_b_pl  = {m1_bid_o, m1_bresp_o};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who owns the port (0 none, 1 m0 read, 2 m1 read,
  // 3 m1 write), whether the owner's address went through, and who was
  // served last. Outputs are derived from these by the forwarding rules.
  // ---------------------------------------------------------------------------
  int owner    = 0;
  bit adone    = 0;
  bit last_srv = 1;

  initial begin : compare
    bit e_sarv, e_arr0, e_arr1, e_srr, e_rv0, e_rv1;
    bit e_sawv, e_awr, e_swv, e_wr, e_bv, e_sbr;
    bit ck_sar, ck_saw, ck_sw, rd_m1;
    logic [48:0] e_sar, e_saw;
    logic [40:0] e_sw;
    forever begin
      @(negedge clk_i);
      {e_sarv, e_arr0, e_arr1, e_srr, e_rv0, e_rv1} = '0;
      {e_sawv, e_awr, e_swv, e_wr, e_bv, e_sbr} = '0;
      ck_sar = 1; ck_saw = 1; ck_sw = 1;
      e_sar = '0; e_saw = '0; e_sw = '0;
      if (!rst_n_i) begin
        owner = 0; adone = 0; last_srv = 1;
      end else if (owner == 1 || owner == 2) begin
        rd_m1 = (owner == 2);
        if (!adone) begin
          e_sarv = rd_m1 ? m1_arvalid_i : m0_arvalid_i;
          e_sar  = rd_m1 ? m1_ar_pl : m0_ar_pl;
          if (rd_m1) e_arr1 = s_arready_i; else e_arr0 = s_arready_i;
        end else ck_sar = 0;
        e_srr = rd_m1 ? m1_rready_i : m0_rready_i;
        if (rd_m1) e_rv1 = s_rvalid_i; else e_rv0 = s_rvalid_i;
        ck_saw = 0; ck_sw = 0;
      end else if (owner == 3) begin
        if (!adone) begin
          e_sawv = m1_awvalid_i;
          e_saw  = m1_aw_pl;
          e_awr  = s_awready_i;
        end else ck_saw = 0;
        e_swv = m1_wvalid_i; e_sw = m1_w_pl; e_wr = s_wready_i;
        e_bv  = s_bvalid_i;  e_sbr = m1_bready_i;
        ck_sar = 0;
      end
      chk("s_arvalid", s_arvalid_o, e_sarv);
      chk("m0_arready", m0_arready_o, e_arr0);
      chk("m1_arready", m1_arready_o, e_arr1);
      chk("s_rready", s_rready_o, e_srr);
      chk("m0_rvalid", m0_rvalid_o, e_rv0);
      chk("m1_rvalid", m1_rvalid_o, e_rv1);
      chk("s_awvalid", s_awvalid_o, e_sawv);
      chk("m1_awready", m1_awready_o, e_awr);
      chk("s_wvalid", s_wvalid_o, e_swv);
      chk("m1_wready", m1_wready_o, e_wr);
      chk("m1_bvalid", m1_bvalid_o, e_bv);
      chk("s_bready", s_bready_o, e_sbr);
      if (ck_sar) chk("s_ar_payload", s_ar_pl, e_sar);
      if (ck_saw) chk("s_aw_payload", s_aw_pl, e_saw);
      if (ck_sw)  chk("s_w_payload", s_w_pl, e_sw);
      if (owner == 1) chk("m0_r_payload", m0_r_pl, s_r_pl);
      if (owner == 2) chk("m1_r_payload", m1_r_pl, s_r_pl);
      if (owner == 3) chk("m1_b_payload", m1_b_pl, s_b_pl);
      // Advance the model with the inputs that will be present at the edge
      if (rst_n_i) begin
        case (owner)
          0: begin
            if (m1_awvalid_i) begin
              owner = 3; last_srv = 1; adone = 0;
            end else if (m0_arvalid_i || m1_arvalid_i) begin
              if (m0_arvalid_i && m1_arvalid_i) owner = last_srv ? 1 : 2;
              else owner = m0_arvalid_i ? 1 : 2;
              last_srv = (owner == 2);
              adone = 0;
            end
          end
          1, 2: begin
            if (e_sarv && s_arready_i) adone = 1;
            if (s_rvalid_i && e_srr && s_rlast_i) owner = 0;
          end
          default: begin
            if (e_sawv && s_awready_i) adone = 1;
            if (s_bvalid_i && e_sbr) owner = 0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    {m0_arid_i, m0_araddr_i, m0_arlen_i, m0_arsize_i, m0_arburst_i} = '0;
    {m1_arid_i, m1_araddr_i, m1_arlen_i, m1_arsize_i, m1_arburst_i} = '0;
    {m1_awid_i, m1_awaddr_i, m1_awlen_i, m1_awsize_i, m1_awburst_i} = '0;
    {m1_wid_i, m1_wdata_i, m1_wstrb_i, m1_wlast_i} = '0;
    {m0_arvalid_i, m1_arvalid_i, m1_awvalid_i, m1_wvalid_i} = '0;
    {m0_rready_i, m1_rready_i, m1_bready_i} = '0;
    {s_rid_i, s_rdata_i, s_rresp_i, s_rlast_i, s_rvalid_i} = '0;
    {s_arready_i, s_awready_i, s_wready_i, s_bid_i, s_bresp_i, s_bvalid_i} = '0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
  endtask

  task automatic rand_inputs();
    m0_ar_rand: begin
      m0_arid_i = 4'($urandom); m0_araddr_i = $urandom; m0_arlen_i = 8'($urandom);
      m0_arsize_i = 3'($urandom); m0_arburst_i = 2'($urandom);
    end
    m1_arid_i = 4'($urandom); m1_araddr_i = $urandom; m1_arlen_i = 8'($urandom);
    m1_arsize_i = 3'($urandom); m1_arburst_i = 2'($urandom);
    m1_awid_i = 4'($urandom); m1_awaddr_i = $urandom; m1_awlen_i = 8'($urandom);
    m1_awsize_i = 3'($urandom); m1_awburst_i = 2'($urandom);
    m1_wid_i = 4'($urandom); m1_wdata_i = $urandom; m1_wstrb_i = 4'($urandom);
    m1_wlast_i = 1'($urandom);
    s_rid_i = 4'($urandom); s_rdata_i = $urandom; s_rresp_i = 2'($urandom);
    s_bid_i = 4'($urandom); s_bresp_i = 2'($urandom);
    m0_arvalid_i = ($urandom_range(0, 1) == 0);
    m1_arvalid_i = ($urandom_range(0, 1) == 0);
    m1_awvalid_i = ($urandom_range(0, 4) == 0);
    m1_wvalid_i  = ($urandom_range(0, 1) == 0);
    m0_rready_i  = ($urandom_range(0, 3) != 0);
    m1_rready_i  = ($urandom_range(0, 3) != 0);
    m1_bready_i  = ($urandom_range(0, 1) == 0);
    s_arready_i  = ($urandom_range(0, 1) == 0);
    s_awready_i  = ($urandom_range(0, 1) == 0);
    s_wready_i   = ($urandom_range(0, 1) == 0);
    s_rvalid_i   = ($urandom_range(0, 1) == 0);
    s_rlast_i    = ($urandom_range(0, 2) == 0);
    s_bvalid_i   = ($urandom_range(0, 2) == 0);
  endtask

  initial begin : stim
    int beat;
    idle_inputs();
    #1 rst_n_i = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;

    // Single m0 read, one beat
    m0_arvalid_i = 1; m0_araddr_i = 32'h8000_0000; s_arready_i = 1;
    #1 chk("t1_idle_arready", m0_arready_o, 1'b0);
    tick();
    #1 chk("t1_arready", m0_arready_o, 1'b1);
    chk("t1_araddr", s_araddr_o, 32'h8000_0000);
    tick();
    m0_arvalid_i = 0; s_arready_i = 0;
    s_rvalid_i = 1; s_rdata_i = 32'h1234_5678; s_rlast_i = 1; m0_rready_i = 1;
    #1 chk("t1_rvalid", m0_rvalid_o, 1'b1);
    chk("t1_rdata", m0_rdata_o, 32'h1234_5678);
    chk("t1_m1_rvalid", m1_rvalid_o, 1'b0);
    tick();
    #1 chk("t1_back_idle", m0_rvalid_o, 1'b0);
    idle_inputs();
    tick();

    // Round-robin between simultaneous readers, starting from reset
    do_reset();
    m0_arvalid_i = 1; m1_arvalid_i = 1; s_arready_i = 1;
    tick();
    #1 chk("t2_first_m0", m0_arready_o, 1'b1);
    chk("t2_first_not_m1", m1_arready_o, 1'b0);
    tick();
    m0_arvalid_i = 0; m1_arvalid_i = 0; s_arready_i = 0;
    s_rvalid_i = 1; s_rlast_i = 1; m0_rready_i = 1;
    tick();
    idle_inputs();
    m0_arvalid_i = 1; m1_arvalid_i = 1; s_arready_i = 1;
    tick();
    #1 chk("t2_second_m1", m1_arready_o, 1'b1);
    chk("t2_second_not_m0", m0_arready_o, 1'b0);
    tick();
    m0_arvalid_i = 0; m1_arvalid_i = 0; s_arready_i = 0;
    s_rvalid_i = 1; s_rlast_i = 1; m1_rready_i = 1;
    tick();
    idle_inputs();
    tick();

    // Write wins over a concurrent read; read follows after B
    m1_awvalid_i = 1; m1_awaddr_i = 32'h100; m0_arvalid_i = 1; m0_araddr_i = 32'h200;
    s_arready_i = 1;
    tick();
    #1 chk("t3_wr_awvalid", s_awvalid_o, 1'b1);
    chk("t3_rd_blocked_a", m0_arready_o, 1'b0);
    tick();
    s_awready_i = 1;
    #1 chk("t3_awready", m1_awready_o, 1'b1);
    tick();
    m1_awvalid_i = 0; s_awready_i = 0; m1_wvalid_i = 1; m1_wlast_i = 1; s_wready_i = 1;
    #1 chk("t3_rd_blocked_b", m0_arready_o, 1'b0);
    tick();
    m1_wvalid_i = 0; s_wready_i = 0; s_bvalid_i = 1; m1_bready_i = 1;
    #1 chk("t3_bvalid", m1_bvalid_o, 1'b1);
    chk("t3_rd_blocked_c", m0_arready_o, 1'b0);
    tick();
    s_bvalid_i = 0; m1_bready_i = 0;
    #1 chk("t3_idle_gap", m0_arready_o, 1'b0);
    tick();
    #1 chk("t3_read_served", m0_arready_o, 1'b1);
    chk("t3_read_addr", s_araddr_o, 32'h200);
    tick();
    m0_arvalid_i = 0; s_arready_i = 0; s_rvalid_i = 1; s_rlast_i = 1; m0_rready_i = 1;
    tick();
    idle_inputs();
    tick();

    // W shows up before AW
    m1_wvalid_i = 1; m1_wstrb_i = 4'b0011; m1_wdata_i = 32'hAABB_CCDD; m1_wlast_i = 1;
    s_wready_i = 1;
    #1 chk("t4_w_held", m1_wready_o, 1'b0);
    tick();
    tick();
    m1_awvalid_i = 1;
    tick();
    #1 chk("t4_wvalid_fwd", s_wvalid_o, 1'b1);
    chk("t4_wstrb", s_wstrb_o, 4'b0011);
    chk("t4_wdata", s_wdata_o, 32'hAABB_CCDD);
    chk("t4_wready", m1_wready_o, 1'b1);
    tick();
    m1_wvalid_i = 0; s_wready_i = 0; s_awready_i = 1;
    #1 chk("t4_awready", m1_awready_o, 1'b1);
    tick();
    m1_awvalid_i = 0; s_awready_i = 0;
    s_bvalid_i = 1; s_bresp_i = 2'b00; s_bid_i = 4'h5; m1_bready_i = 1;
    #1 chk("t4_bvalid", m1_bvalid_o, 1'b1);
    chk("t4_bresp", m1_bresp_o, 2'b00);
    chk("t4_bid", m1_bid_o, 4'h5);
    tick();
    idle_inputs();
    tick();

    // m1 four-beat read with a stalling consumer
    m1_arvalid_i = 1; m1_arlen_i = 8'd3; s_arready_i = 1;
    tick();
    tick();
    m1_arvalid_i = 0; s_arready_i = 0;
    beat = 0;
    for (int cyc = 0; cyc < 12 && beat < 4; cyc++) begin
      s_rvalid_i = 1; s_rdata_i = 32'hD0 + beat; s_rlast_i = (beat == 3);
      m1_rready_i = cyc[0];
      #1 chk("t5_rvalid", m1_rvalid_o, 1'b1);
      chk("t5_rdata", m1_rdata_o, 32'hD0 + beat);
      if (m1_rready_i) beat++;
      tick();
    end
    #1 chk("t5_exit_after_last", m1_rvalid_o, 1'b0);
    idle_inputs();
    tick();

    // Reset in the middle of an m1 burst
    m1_arvalid_i = 1; s_arready_i = 1;
    tick();
    tick();
    m1_arvalid_i = 0; s_arready_i = 0; s_rvalid_i = 1; s_rlast_i = 0; m1_rready_i = 1;
    #1 chk("t6_midburst", m1_rvalid_o, 1'b1);
    tick();
    #2 rst_n_i = 1'b0;
    #1 chk("t6_rst_rvalid", m1_rvalid_o, 1'b0);
    chk("t6_rst_rready", s_rready_o, 1'b0);
    tick();
    idle_inputs();
    m0_arvalid_i = 1; m1_arvalid_i = 1; s_arready_i = 1;
    tick();
    rst_n_i = 1'b1;
    tick();
    #1 chk("t6_last_is_1", m0_arready_o, 1'b1);
    chk("t6_m1_waits", m1_arready_o, 1'b0);
    tick();
    m0_arvalid_i = 0; m1_arvalid_i = 0; s_arready_i = 0;
    s_rvalid_i = 1; s_rlast_i = 1; m0_rready_i = 1;
    tick();
    idle_inputs();
    tick();

    // Random traffic against the model, with occasional resets
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      rst_n_i = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n_i = 1'b1;
    idle_inputs();
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
